rv_sdram_bridge: RTL

- Upstream adapter between the RISC-V softcore's 32-bit valid/ready memory bus and the SDRAM controller's 16-bit toggle-handshake RV port (bank 1, 2 MB).
- Splits each 32-bit access into up to two halfword transactions, low half first.
- Handles byte strobes and skips halfwords whose strobes are all zero.
- Reassembles read data and returns a one-cycle mem_ready pulse.

---
 rtl/nes_mem_pkg.sv | 26 ++
 rtl/rv_word_cache.sv | 54 +++++
 rtl/rv_sdram_bridge.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/nes_mem_pkg.sv
// Shared types and constants for the CPU-to-SDRAM bridge: FSM states, halfword selects,
// address width and the halfword issue-order helper.
package nes_mem_pkg;

  localparam int unsigned RV_AW = 21;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    StResync,
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StDone
  } br_state_e;

  // Picks the next pending halfword; pend[0] is the low half, pend[1] the high half.
  function automatic logic pick_half(input logic [1:0] pend, input logic hi_first);
    if (hi_first) begin
      return pend[1] ? HALF_HI : HALF_LO;
    end
    return pend[0] ? HALF_LO : HALF_HI;
  endfunction

endpackage

// File: rtl/rv_word_cache.sv
// Single-entry word read cache: tag compare, refill on read completion and byte merge of
// writes that hit the cached word.
module rv_word_cache
  import nes_mem_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [RV_AW-3:0] lookup_addr_i,
  output logic             hit_o,
  output logic [31:0]      rdata_o,
  input  logic             fill_i,
  input  logic [RV_AW-3:0] fill_addr_i,
  input  logic [31:0]      fill_data_i,
  input  logic             wr_i,
  input  logic [RV_AW-3:0] wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  logic [3:0]       wr_strb_i
);

  logic             valid_q, valid_d;
  logic [RV_AW-3:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_addr_i;
      data_d  = fill_data_i;
    end else if (wr_i && valid_q && (wr_addr_i == tag_q)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) data_d[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o   = valid_q && (tag_q == lookup_addr_i);
  assign rdata_o = data_q;

endmodule

// File: rtl/rv_sdram_bridge.sv
// 32-bit valid/ready CPU bus to 16-bit toggle-handshake SDRAM port bridge.
// Optional single-entry read cache enabled by defining RV_SDRAM_WORD_CACHE_EN.
module rv_sdram_bridge
  import nes_mem_pkg::*;
#(
  parameter int unsigned HI_FIRST = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sdram_busy,
  input  logic             mem_valid,
  input  logic [RV_AW-1:0] mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  output logic [19:0]      rv_addr,
  output logic [15:0]      rv_din,
  output logic [1:0]       rv_ds,
  output logic             rv_we,
  output logic             rv_req,
  input  logic             rv_req_ack,
  input  logic [15:0]      rv_dout
);

  localparam logic HiFirst = (HI_FIRST != 0);

  br_state_e        state_q, state_d;
  logic [RV_AW-3:0] waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0]       pend_q, pend_d;
  logic             half_q, half_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             req_q, req_d;
  logic [19:0]      rv_addr_q, rv_addr_d;
  logic [15:0]      rv_din_q, rv_din_d;
  logic [1:0]       rv_ds_q, rv_ds_d;
  logic             rv_we_q, rv_we_d;

  logic       accept, is_rd, ack_eq;
  logic [1:0] pend_new;
  logic       cache_hit;
  logic [31:0] cache_rdata;
  logic       unused_addr;

  assign unused_addr = ^mem_addr[1:0];
  assign accept      = (state_q == StIdle) && mem_valid && !sdram_busy;
  assign is_rd       = (wstrb_q == 4'b0000);
  assign ack_eq      = (rv_req_ack == req_q);
  assign pend_new    = {(mem_wstrb == 4'b0000) || (|mem_wstrb[3:2]),
                        (mem_wstrb == 4'b0000) || (|mem_wstrb[1:0])};

`ifdef RV_SDRAM_WORD_CACHE_EN
  logic cache_tag_hit;

  rv_word_cache u_cache (
    .clk_i         (clk),
    .rst_ni        (resetn),
    .lookup_addr_i (mem_addr[RV_AW-1:2]),
    .hit_o         (cache_tag_hit),
    .rdata_o       (cache_rdata),
    .fill_i        ((state_q == StDone) && is_rd),
    .fill_addr_i   (waddr_q),
    .fill_data_i   (rdata_q),
    .wr_i          (accept && (mem_wstrb != 4'b0000)),
    .wr_addr_i     (mem_addr[RV_AW-1:2]),
    .wr_data_i     (mem_wdata),
    .wr_strb_i     (mem_wstrb)
  );

  assign cache_hit = cache_tag_hit && (mem_wstrb == 4'b0000);
`else
  assign cache_hit   = 1'b0;
  assign cache_rdata = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StResync;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StResync:  state_d = StIdle;
      StIdle:    if (accept) state_d = cache_hit ? StDone : StIssue;
      StIssue:   state_d = StWait;
      StWait: begin
        if (ack_eq) begin
          if (is_rd)        state_d = StCapture;
          else if (|pend_q) state_d = StIssue;
          else              state_d = StDone;
        end
      end
      StCapture: state_d = (|pend_q) ? StIssue : StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StResync;
    endcase
  end

  always_comb begin
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    pend_d    = pend_q;
    half_d    = half_q;
    rdata_d   = rdata_q;
    req_d     = req_q;
    rv_addr_d = rv_addr_q;
    rv_din_d  = rv_din_q;
    rv_ds_d   = rv_ds_q;
    rv_we_d   = rv_we_q;
    unique case (state_q)
      // Adopt the controller's unreset ack level so nothing looks outstanding.
      StResync: req_d = rv_req_ack;
      StIdle: begin
        if (accept) begin
          waddr_d = mem_addr[RV_AW-1:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          pend_d  = pend_new;
          half_d  = pick_half(pend_new, HiFirst);
          if (cache_hit) rdata_d = cache_rdata;
        end
      end
      StIssue: begin
        rv_addr_d      = {waddr_q, half_q};
        rv_din_d       = half_q ? wdata_q[31:16] : wdata_q[15:0];
        rv_ds_d        = is_rd ? 2'b11 : (half_q ? wstrb_q[3:2] : wstrb_q[1:0]);
        rv_we_d        = !is_rd;
        req_d          = ~req_q;
        pend_d[half_q] = 1'b0;
      end
      StWait: begin
        if (ack_eq && !is_rd && (|pend_q)) half_d = pick_half(pend_q, HiFirst);
      end
      StCapture: begin
        if (half_q) rdata_d[31:16] = rv_dout;
        else        rdata_d[15:0]  = rv_dout;
        if (|pend_q) half_d = pick_half(pend_q, HiFirst);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pend_q    <= '0;
      half_q    <= HALF_LO;
      rdata_q   <= '0;
      req_q     <= 1'b0;
      rv_addr_q <= '0;
      rv_din_q  <= '0;
      rv_ds_q   <= '0;
      rv_we_q   <= 1'b0;
    end else begin
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      pend_q    <= pend_d;
      half_q    <= half_d;
      rdata_q   <= rdata_d;
      req_q     <= req_d;
      rv_addr_q <= rv_addr_d;
      rv_din_q  <= rv_din_d;
      rv_ds_q   <= rv_ds_d;
      rv_we_q   <= rv_we_d;
    end
  end

  always_comb begin
    mem_ready = (state_q == StDone);
    mem_rdata = rdata_q;
    rv_addr   = rv_addr_q;
    rv_din    = rv_din_q;
    rv_ds     = rv_ds_q;
    rv_we     = rv_we_q;
    rv_req    = req_q;
  end

endmodule
